// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: bundles the two request channels, the ALU operand/result
// path and the response channel of the shared-ALU arbiter.
//   req0_* / req1_*  : valid/ready request channels (opcode, oper1, oper2)
//   alu_*            : registered operands to the ALU, combinational result back
//   rsp_*            : response channel tagged with the requester id
//   busy             : arbiter has an operation in flight
// Modports: slave = arbiter side, master = requesters/ALU/consumer side.
interface alu_arbiter_if #(
   parameter int P_OPW = 4,
   parameter int P_DW  = 8
);
   logic              req0_valid;
   logic              req0_ready;
   logic [P_OPW-1:0]  req0_opcode;
   logic [P_DW-1:0]   req0_oper1;
   logic [P_DW-1:0]   req0_oper2;

   logic              req1_valid;
   logic              req1_ready;
   logic [P_OPW-1:0]  req1_opcode;
   logic [P_DW-1:0]   req1_oper1;
   logic [P_DW-1:0]   req1_oper2;

   logic [P_OPW-1:0]  alu_opcode;
   logic [P_DW-1:0]   alu_oper1;
   logic [P_DW-1:0]   alu_oper2;
   logic [P_DW-1:0]   alu_res;
   logic [2:0]        alu_status;

   logic              rsp_valid;
   logic              rsp_id;
   logic [P_DW-1:0]   rsp_res;
   logic [2:0]        rsp_status;
   logic              rsp_ready;

   logic              busy;

   modport slave (
      input  req0_valid, req0_opcode, req0_oper1, req0_oper2,
      output req0_ready,
      input  req1_valid, req1_opcode, req1_oper1, req1_oper2,
      output req1_ready,
      output alu_opcode, alu_oper1, alu_oper2,
      input  alu_res, alu_status,
      output rsp_valid, rsp_id, rsp_res, rsp_status,
      input  rsp_ready,
      output busy
   );

   modport master (
      output req0_valid, req0_opcode, req0_oper1, req0_oper2,
      input  req0_ready,
      output req1_valid, req1_opcode, req1_oper1, req1_oper2,
      input  req1_ready,
      input  alu_opcode, alu_oper1, alu_oper2,
      output alu_res, alu_status,
      input  rsp_valid, rsp_id, rsp_res, rsp_status,
      output rsp_ready,
      input  busy
   );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Round-robin grant, registered ALU operands, one operation in flight,
// response captured one cycle after the grant and held until accepted.
// Ports:
//   clk    : clock, all state on the rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : alu_arbiter_if.slave (request, ALU and response channels, busy)
//
// state | meaning
// IDLE  | waiting for a request, grant is combinational from the valids
// EXEC  | operands on the ALU, result captured at the end of this cycle
// RESP  | response held until rsp_ready is sampled high
module alu_arbiter (
   input  logic          clk,
   input  logic          rst_n,
   alu_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   logic   gnt_valid;
   logic   gnt_id;
   logic   last_gnt;   // requester granted most recently; the other wins ties
   logic   id_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next     = state;
      gnt_valid      = 1'b0;
      gnt_id         = 1'b0;
      bus.req0_ready = 1'b0;
      bus.req1_ready = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.req0_valid && bus.req1_valid) begin
               gnt_valid = 1'b1;
               gnt_id    = ~last_gnt;
            end else if (bus.req0_valid) begin
               gnt_valid = 1'b1;
               gnt_id    = 1'b0;
            end else if (bus.req1_valid) begin
               gnt_valid = 1'b1;
               gnt_id    = 1'b1;
            end
            bus.req0_ready = gnt_valid & ~gnt_id;
            bus.req1_ready = gnt_valid & gnt_id;
            if (gnt_valid) begin
               state_next = ST_EXEC;
            end
         end
         ST_EXEC: begin
            state_next = ST_RESP;
         end
         ST_RESP: begin
            if (bus.rsp_ready) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign bus.busy = (state != ST_IDLE);

   // gnt_valid can only be set in IDLE, so the ALU operands stay put
   // from one grant to the next.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_gnt       <= 1'b1;
         id_q           <= 1'b0;
         bus.alu_opcode <= '0;
         bus.alu_oper1  <= '0;
         bus.alu_oper2  <= '0;
         bus.rsp_valid  <= 1'b0;
         bus.rsp_id     <= 1'b0;
         bus.rsp_res    <= '0;
         bus.rsp_status <= '0;
      end else begin
         if (gnt_valid) begin
            last_gnt <= gnt_id;
            id_q     <= gnt_id;
            if (gnt_id) begin
               bus.alu_opcode <= bus.req1_opcode;
               bus.alu_oper1  <= bus.req1_oper1;
               bus.alu_oper2  <= bus.req1_oper2;
            end else begin
               bus.alu_opcode <= bus.req0_opcode;
               bus.alu_oper1  <= bus.req0_oper1;
               bus.alu_oper2  <= bus.req0_oper2;
            end
         end
         if (state == ST_EXEC) begin
            bus.rsp_valid  <= 1'b1;
            bus.rsp_id     <= id_q;
            bus.rsp_res    <= bus.alu_res;
            bus.rsp_status <= bus.alu_status;
         end else if ((state == ST_RESP) && bus.rsp_ready) begin
            bus.rsp_valid  <= 1'b0;
         end
      end
   end

endmodule
